sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM read port among NUM_REQ sprite colour mappers (apple, snake head, snake body, score digits).
- Each mapper fetches 32-bit words, each holding 8 packed 4-bit palette indices.
- Round-robin arbitration, one ROM read issued per cycle, fully pipelined.
- Each response is returned on a shared data bus with a one-hot per-requester valid strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, ROM word address width
- DATA_W, 32, ROM word width (8 pixels x 4 bits)
- RD_LAT, 2, ROM read latency in cycles, from rom_en/rom_addr sampled to rom_rdata valid (1..4)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester fetch request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM read address
- rom_rdata  in  DATA_W  ROM read data
- rsp_valid  out  NUM_REQ  one-hot; high for exactly one cycle per accepted request
- rsp_data  out  DATA_W  registered ROM word; valid only when rsp_valid is nonzero

Behaviour:
- Clock and reset: single clock, Clk. Reset is asynchronous, active-high.
- Reset values: req_ready=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, rr_ptr=0, tag pipeline cleared.
- Grant (combinational):
  - Search requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other req_ready bits are 0.
  - With no requests, req_ready=0.
- Requester rule: req_valid and req_addr must stay stable until the handshake. The arbiter never drops an asserted request.
- rr_ptr update at a handshake edge: rr_ptr <= (granted i + 1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue stage (registered):
  - At the handshake edge, rom_en <= 1 and rom_addr <= granted address.
  - With no handshake, rom_en <= 0 and rom_addr holds.
  - A one-hot tag (granted i) enters a shift pipeline of depth RD_LAT+1, alongside rom_en.
- Return stage:
  - When the tag emerges, rsp_data <= rom_rdata and rsp_valid <= tag, both registered.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: fixed. Handshake at edge k gives rsp_valid high during the cycle after edge k+RD_LAT+1 (e.g. RD_LAT=2: 3 edges after the handshake).
- Throughput: one request accepted per cycle. Responses return in acceptance order, with no reordering and no backpressure on responses.
- Cycle-level states: IDLE (no tags in flight) and BUSY (at least one tag in flight) are derived from the pipeline occupancy and have no external visibility. Arbitration is identical in both.
- Boundary conditions:
  - Single requester streaming: granted every cycle, rr_ptr toggles past it harmlessly.
  - All requesters active: grants rotate strictly 0,1,...,NUM_REQ-1; worst-case wait is NUM_REQ-1 cycles.
  - rr_ptr wrap: after granting NUM_REQ-1, rr_ptr=0.
  - Same address from two requesters on consecutive cycles: two independent reads and two responses.
- Reset mid-operation: all in-flight tags are discarded, so no rsp_valid is produced for requests accepted before Reset. Arbitration restarts at requester 0 on the first edge after Reset deasserts.

Optional Feature:
- Macro: SPRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requester with req_valid wins every cycle. rr_ptr is not implemented. Latency and pipeline are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single request: req_valid[2]=1, addr=12'h040, ROM word 32'h1234_5678 at 0x040 (RD_LAT=2) -> req_ready=4'b0100 same cycle; rom_en=1, rom_addr=12'h040 the next cycle; rsp_valid=4'b0100 with rsp_data=32'h1234_5678 three edges after the handshake, for one cycle.
- All four requesting simultaneously, addrs 0x10/0x20/0x30/0x40 -> req_ready 0001, 0010, 0100, 1000 on four consecutive cycles; responses in the same order on four consecutive cycles with the matching words.
- Requester 0 and requester 2 held continuously -> grants alternate 0,2,0,2...; requesters 1 and 3 never granted; no cycle without a grant.
- Requester 3 streams 8 addresses back-to-back, others idle -> 8 consecutive rom_en cycles; 8 consecutive rsp_valid=4'b1000 with the correct words in order.
- Reset asserted asynchronously with 2 requests in flight -> all outputs 0 immediately; no rsp_valid after deassert; first subsequent grant goes to the lowest requesting index.
- With SPRITE_ARB_FIXED_PRIO_EN defined, requesters 0 and 1 held continuously -> requester 0 granted every cycle and requester 1 never; after dropping req_valid[0], requester 1 is granted on the next cycle.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM port; 1 grant/cycle, response RD_LAT+1 edges after handshake, no response backpressure.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_rdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                   r_state, w_state_nxt;
  logic [RD_LAT:0][NUM_REQ-1:0] r_tag;
  logic [NUM_REQ-1:0]       w_grant;
  logic [ADDR_W-1:0]        w_grant_addr;
  logic                     w_hs;
  logic                     w_shift;

  function automatic logic [NUM_REQ-1:0] f_lowest(input logic [NUM_REQ-1:0] v);
    f_lowest = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        f_lowest    = '0;
        f_lowest[i] = 1'b1;
      end
    end
  endfunction

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = f_lowest(req_valid);
  end
`else
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_gidx;
  logic [NUM_REQ-1:0] w_mask_hi;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask_hi[i] = req_valid[i] && (PTR_W'(i) >= r_rr_ptr);
    end
    w_grant = (|w_mask_hi) ? f_lowest(w_mask_hi) : f_lowest(req_valid);
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end
`endif

  always_comb begin
    w_grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_hs      = |w_grant;
  assign req_ready = Reset ? '0 : w_grant;

  // Pipeline occupancy FSM: the tag shifter only clocks while something is in flight.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE:  w_shift = w_hs;
      S_BUSY:  w_shift = 1'b1;
      default: w_shift = 1'b1;
    endcase
    if (w_hs || (|r_tag[RD_LAT-1:0])) w_state_nxt = S_BUSY;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_tag     <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      rom_en  <= w_hs;
      if (w_hs) rom_addr <= w_grant_addr;
      if (w_shift) r_tag <= {r_tag[RD_LAT-1:0], w_grant};
      // The oldest tag lines up with the ROM word for that request.
      if (|r_tag[RD_LAT]) begin
        rsp_valid <= r_tag[RD_LAT];
        rsp_data  <= rom_rdata;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 2-cycle synchronous ROM model.
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_rdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [DW-1:0]    rom_p1;

  int n_vec = 0;
  int n_bad = 0;

  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 12'h040) return 32'h1234_5678;
    return {a, ~a, 8'hC3};
  endfunction

  // Sampled at one edge, data on rom_rdata after the next edge.
  always @(posedge Clk) begin
    if (rom_en) rom_p1 <= rom_word(rom_addr);
    rom_rdata <= rom_p1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
  endtask

  logic [NR-1:0] v;

  initial begin
    Reset = 1'b0; req_valid = '0; req_addr = '0; rom_p1 = '0; rom_rdata = '0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    req_valid = 4'b1111; #1;
    chk("rst_ready", req_ready, 0);
    do_reset();

    // Single request from requester 2
    set_addr(2, 12'h040); req_valid = 4'b0100; #1;
    chk("t1_ready", req_ready, 4'b0100);
    tick(); req_valid = '0; #1;
    chk("t1_rom_en", rom_en, 1);
    chk("t1_rom_addr", rom_addr, 12'h040);
    chk("t1_rsp_early", rsp_valid, 0);
    for (int n = 1; n <= 4; n++) begin
      tick(); #1;
      chk("t1_rom_en_off", rom_en, 0);
      chk("t1_rsp_valid", rsp_valid, (n == 3) ? 4'b0100 : 4'b0000);
      if (n >= 3) chk("t1_rsp_data", rsp_data, 32'h1234_5678);
    end

    // All four at once: strict rotation, in-order responses
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, AW'(16 * (i + 1)));
    v = 4'b1111; req_valid = v; #1;
    for (int n = 0; n < 8; n++) begin
      chk("t2_ready", req_ready, (n < 4) ? (4'b0001 << n) : 4'b0000);
      tick();
      if (n < 4) v = v & ~(4'b0001 << n);
      req_valid = v; #1;
      chk("t2_rom_en", rom_en, (n < 4) ? 1 : 0);
      if (n < 4) chk("t2_rom_addr", rom_addr, 16 * (n + 1));
      if (n >= 3 && n < 7) begin
        chk("t2_rsp_valid", rsp_valid, 4'b0001 << (n - 3));
        chk("t2_rsp_data", rsp_data, rom_word(AW'(16 * (n - 2))));
      end else begin
        chk("t2_rsp_idle", rsp_valid, 0);
      end
    end
    // Pointer wrapped to 0 after granting requester 3
    req_valid = 4'b1001; #1;
    chk("t2_wrap", req_ready, 4'b0001);
    req_valid = '0; #1;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    do_reset();
    set_addr(0, 12'h100); set_addr(1, 12'h110);
    req_valid = 4'b0011; #1;
    for (int n = 0; n < 4; n++) begin
      chk("t3_fixed_ready", req_ready, 4'b0001);
      tick(); #1;
      chk("t3_fixed_addr", rom_addr, 12'h100);
    end
    req_valid = 4'b0010; #1;
    chk("t3_fixed_r1", req_ready, 4'b0010);
    tick(); req_valid = '0; #1;
    chk("t3_fixed_r1_addr", rom_addr, 12'h110);
`else
    do_reset();
    set_addr(0, 12'h100); set_addr(2, 12'h120);
    req_valid = 4'b0101; #1;
    for (int n = 0; n < 8; n++) begin
      chk("t3_alt_ready", req_ready, (n % 2 == 1) ? 4'b0100 : 4'b0001);
      tick(); #1;
      chk("t3_alt_rom_en", rom_en, 1);
      chk("t3_alt_addr", rom_addr, (n % 2 == 1) ? 12'h120 : 12'h100);
    end
    req_valid = '0; #1;
    chk("t3_no_req", req_ready, 0);
`endif
    for (int n = 0; n < 4; n++) tick();

    // Requester 3 streams 8 addresses back-to-back
    set_addr(3, 12'h300); req_valid = 4'b1000; #1;
    for (int n = 0; n < 12; n++) begin
      chk("t4_ready", req_ready, (n < 8) ? 4'b1000 : 4'b0000);
      tick();
      if (n + 1 < 8) set_addr(3, AW'(12'h300 + n + 1));
      else req_valid = '0;
      #1;
      chk("t4_rom_en", rom_en, (n < 8) ? 1 : 0);
      if (n < 8) chk("t4_rom_addr", rom_addr, 12'h300 + n);
      if (n >= 3 && n < 11) begin
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        chk("t4_rsp_data", rsp_data, rom_word(AW'(12'h300 + n - 3)));
      end else begin
        chk("t4_rsp_idle", rsp_valid, 0);
      end
    end

    // Reset with two requests in flight
    set_addr(0, 12'h050); set_addr(1, 12'h060);
    req_valid = 4'b0011; #1;
    chk("t5_ready0", req_ready, 4'b0001);
    tick(); req_valid = 4'b0010; #1;
    chk("t5_ready1", req_ready, 4'b0010);
    tick(); req_valid = '0; #1;
    Reset = 1'b1; #1;
    chk("t5_rom_en", rom_en, 0);
    chk("t5_rom_addr", rom_addr, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    req_valid = 4'b0101; #1;
    chk("t5_ready_in_rst", req_ready, 0);
    tick();
    chk("t5_rsp_in_rst", rsp_valid, 0);
    tick();
    Reset = 1'b0; req_valid = '0; #1;
    for (int n = 0; n < 4; n++) begin
      tick(); #1;
      chk("t5_no_stale_rsp", rsp_valid, 0);
    end

    // Same address from two requesters on consecutive cycles
    set_addr(0, 12'h040); set_addr(1, 12'h040);
    req_valid = 4'b0011; #1;
    chk("t6_first_grant", req_ready, 4'b0001);
    tick(); req_valid = 4'b0010; #1;
    chk("t6_ready1", req_ready, 4'b0010);
    chk("t6_rom_addr0", rom_addr, 12'h040);
    tick(); req_valid = '0; #1;
    chk("t6_rom_en1", rom_en, 1);
    chk("t6_rom_addr1", rom_addr, 12'h040);
    tick(); #1;
    chk("t6_rsp_wait", rsp_valid, 0);
    tick(); #1;
    chk("t6_rsp0", rsp_valid, 4'b0001);
    chk("t6_rsp0_data", rsp_data, 32'h1234_5678);
    tick(); #1;
    chk("t6_rsp1", rsp_valid, 4'b0010);
    chk("t6_rsp1_data", rsp_data, 32'h1234_5678);
    tick(); #1;
    chk("t6_rsp_done", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
